// File: rtl/fp_div.sv
`default_nettype none
// ============================================================================
// Module   : fp_div
// Brief    : IEEE-754 binary16 divider; 13-cycle restoring iteration, RNE rounding.
//            Define FP_DIV_SUBNORMAL_EN for gradual underflow (default: flush to zero).
// Revision : 1.0
// ============================================================================
module fp_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        sNaN_o,
    output logic        qNaN_o,
    output logic        infinity_o,
    output logic        zero_o,
    output logic        subnormal_o,
    output logic        normal_o,
    output logic        div_zero_o
);

`ifdef FP_DIV_SUBNORMAL_EN
    localparam logic c_SUB_EN = 1'b1;
`else
    localparam logic c_SUB_EN = 1'b0;
`endif

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PRE  = 3'd1;
    localparam logic [2:0] c_CALC = 3'd2;
    localparam logic [2:0] c_RND  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    // {sNaN, qNaN, inf, zero}; subnormals count as zero when gradual underflow is off
    function automatic logic [3:0] classify(input logic [14:0] x);
        logic e_max;
        logic f_nz;
        e_max = &x[14:10];
        f_nz  = |x[9:0];
        classify = {e_max & f_nz & ~x[9], e_max & x[9], e_max & ~f_nz,
                    (x[14:10] == 5'd0) & (~f_nz | ~c_SUB_EN)};
    endfunction

    function automatic logic [3:0] norm_shift(input logic [9:0] f);
        norm_shift = 4'd0;
        for (int i = 0; i < 10; i++)
            if (f[i]) norm_shift = 4'(10 - i);
    endfunction

    // {unbiased exponent[7:0], significand with hidden bit[10:0]}
    function automatic logic [18:0] unpack(input logic [14:0] x);
        logic [3:0] sh;
        sh = norm_shift(x[9:0]);
        if (x[14:10] != 5'd0)
            unpack = {8'({3'b0, x[14:10]}) - 8'd15, 1'b1, x[9:0]};
        else
            unpack = {8'd0 - 8'd14 - 8'({4'b0, sh}), 11'({1'b0, x[9:0]} << sh)};
    endfunction

    logic [2:0]         r_state;
    logic [15:0]        r_a, r_b;
    logic               r_sign, r_special;
    logic signed [7:0]  r_exp;
    logic [10:0]        r_mb, r_mant;
    logic [11:0]        r_rem;
    logic [12:0]        r_quo;
    logic [3:0]         r_cnt;
    logic               r_out_valid;
    logic [15:0]        r_q;
    logic [6:0]         r_flags;

    logic [3:0]         w_cls_ia, w_cls_ib, w_ca, w_cb;
    logic               w_in_special;
    logic [18:0]        w_ua, w_ub;
    logic [12:0]        w_diff;
    logic               w_ge;
    logic [11:0]        w_rem_sel;
    logic               w_msb, w_g0, w_s0, w_den, w_g1, w_s1, w_up;
    logic [10:0]        w_m0, w_m1, w_mn, w_rnd_mant;
    logic signed [7:0]  w_e0, w_e1, w_er, w_shf;
    logic [3:0]         w_sh;
    logic [24:0]        w_ext;
    logic [11:0]        w_mr;
    logic [15:0]        w_res_q;
    logic [6:0]         w_res_fl;

    assign w_cls_ia     = classify(op_a[14:0]);
    assign w_cls_ib     = classify(op_b[14:0]);
    assign w_in_special = (|w_cls_ia) | (|w_cls_ib);
    assign w_ca         = classify(r_a[14:0]);
    assign w_cb         = classify(r_b[14:0]);
    assign w_ua         = unpack(r_a[14:0]);
    assign w_ub         = unpack(r_b[14:0]);

    assign w_diff    = {1'b0, r_rem} - {2'b0, r_mb};
    assign w_ge      = ~w_diff[12];
    assign w_rem_sel = w_ge ? w_diff[11:0] : r_rem;

    // Quotient lies in (0.5, 2): a clear MSB means one extra normalising shift
    assign w_msb = r_quo[12];
    assign w_m0  = w_msb ? r_quo[12:2] : r_quo[11:1];
    assign w_g0  = w_msb ? r_quo[1] : r_quo[0];
    assign w_s0  = (w_msb & r_quo[0]) | (|r_rem);
    assign w_e0  = w_msb ? r_exp : r_exp - 8'sd1;

    // Denormalising shift saturates at 13: beyond that only sticky survives
    assign w_den = c_SUB_EN && (w_e0 < -8'sd14);
    assign w_shf = -8'sd14 - w_e0;
    assign w_sh  = w_den ? ((w_shf > 8'sd13) ? 4'd13 : w_shf[3:0]) : 4'd0;
    assign w_ext = {w_m0, w_g0, 13'b0} >> w_sh;
    assign w_m1  = w_ext[24:14];
    assign w_g1  = w_ext[13];
    assign w_s1  = w_s0 | (|w_ext[12:0]);
    assign w_e1  = w_den ? -8'sd14 : w_e0;

    assign w_up       = w_g1 & (w_s1 | w_m1[0]);
    assign w_mr       = {1'b0, w_m1} + {11'b0, w_up};
    assign w_er       = w_mr[11] ? w_e1 + 8'sd1 : w_e1;
    assign w_mn       = w_mr[11] ? w_mr[11:1] : w_mr[10:0];
    assign w_rnd_mant = (!c_SUB_EN && (w_er < -8'sd14)) ? 11'd0 : w_mn;

    // Result packing; flag order {sNaN, qNaN, inf, zero, subnormal, normal, div_zero}
    always_comb begin
        w_res_q  = 16'h0000;
        w_res_fl = 7'b0000000;
        if (r_special) begin
            if (w_ca[3]) begin
                w_res_q = r_a | 16'h0200;  w_res_fl = 7'b1000000;
            end else if (w_cb[3]) begin
                w_res_q = r_b | 16'h0200;  w_res_fl = 7'b1000000;
            end else if (w_ca[2]) begin
                w_res_q = r_a;             w_res_fl = 7'b0100000;
            end else if (w_cb[2]) begin
                w_res_q = r_b;             w_res_fl = 7'b0100000;
            end else if ((w_ca[0] & w_cb[0]) | (w_ca[1] & w_cb[1])) begin
                w_res_q = 16'h7E00;        w_res_fl = 7'b0100000;
            end else if (w_ca[1]) begin
                w_res_q = {r_sign, 15'h7C00}; w_res_fl = 7'b0010000;
            end else if (w_cb[0]) begin
                w_res_q = {r_sign, 15'h7C00}; w_res_fl = 7'b0010001;
            end else begin
                w_res_q = {r_sign, 15'h0000}; w_res_fl = 7'b0001000;
            end
        end else if (r_exp > 8'sd15) begin
            w_res_q = {r_sign, 15'h7C00}; w_res_fl = 7'b0010000;
        end else if (r_mant[10]) begin
            w_res_q = {r_sign, r_exp[4:0] + 5'd15, r_mant[9:0]}; w_res_fl = 7'b0000010;
        end else if ((r_mant == 11'd0) || !c_SUB_EN) begin
            w_res_q = {r_sign, 15'h0000}; w_res_fl = 7'b0001000;
        end else begin
            w_res_q = {r_sign, 5'd0, r_mant[9:0]}; w_res_fl = 7'b0000100;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_sign      <= 1'b0;
            r_special   <= 1'b0;
            r_exp       <= 8'sd0;
            r_mb        <= 11'd0;
            r_mant      <= 11'd0;
            r_rem       <= 12'd0;
            r_quo       <= 13'd0;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_q         <= 16'h0000;
            r_flags     <= 7'b0000000;
        end else begin
            case (r_state)
                c_IDLE: if (in_valid) begin
                    r_a       <= op_a;
                    r_b       <= op_b;
                    r_sign    <= op_a[15] ^ op_b[15];
                    r_special <= w_in_special;
                    r_state   <= w_in_special ? c_DONE : c_PRE;
                end
                c_PRE: begin
                    r_exp   <= w_ua[18:11] - w_ub[18:11];
                    r_rem   <= {1'b0, w_ua[10:0]};
                    r_mb    <= w_ub[10:0];
                    r_quo   <= 13'd0;
                    r_cnt   <= 4'd0;
                    r_state <= c_CALC;
                end
                c_CALC: begin
                    r_quo <= {r_quo[11:0], w_ge};
                    r_rem <= {w_rem_sel[10:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd12) r_state <= c_RND;
                end
                c_RND: begin
                    r_mant  <= w_rnd_mant;
                    r_exp   <= w_er;
                    r_state <= c_DONE;
                end
                c_DONE: if (!r_out_valid) begin
                    r_q         <= w_res_q;
                    r_flags     <= w_res_fl;
                    r_out_valid <= 1'b1;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == c_IDLE);
    assign out_valid   = r_out_valid;
    assign q           = r_q;
    assign sNaN_o      = r_flags[6];
    assign qNaN_o      = r_flags[5];
    assign infinity_o  = r_flags[4];
    assign zero_o      = r_flags[3];
    assign subnormal_o = r_flags[2];
    assign normal_o    = r_flags[1];
    assign div_zero_o  = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_fp_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div
// Brief    : Scoreboard bench for fp_div; real-arithmetic reference for random operands.
// Revision : 1.0
// ============================================================================
module tb_fp_div;

`ifdef FP_DIV_SUBNORMAL_EN
    localparam bit c_SUB = 1'b1;
`else
    localparam bit c_SUB = 1'b0;
`endif

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] op_a, op_b, q;
    logic        sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o, div_zero_o;
    logic [6:0]  w_fl;

    int          n_vec, n_bad;
    logic [22:0] sb_q[$];

    fp_div u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .sNaN_o(sNaN_o), .qNaN_o(qNaN_o), .infinity_o(infinity_o),
        .zero_o(zero_o), .subnormal_o(subnormal_o), .normal_o(normal_o),
        .div_zero_o(div_zero_o)
    );

    assign w_fl = {sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o, div_zero_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int e, f;
        e = int'(h[14:10]);
        f = int'(h[9:0]);
        if (e == 0) return real'(f) * pow2(-24);
        return real'(1024 + f) * pow2(e - 25);
    endfunction

    function automatic int rne(input real s);
        real fl;
        int  i;
        fl = $floor(s);
        i  = $rtoi(fl);
        if ((s - fl > 0.5) || ((s - fl == 0.5) && (i % 2 == 1))) i++;
        return i;
    endfunction

    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] rq, output logic [6:0] rf, output bit sp);
        logic sg, na, nb, sa, sb, ia, ib, za, zb;
        real  x;
        int   e, m;
        sg = a[15] ^ b[15];
        na = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        nb = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        sa = na && !a[9];
        sb = nb && !b[9];
        ia = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        ib = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        za = (a[14:10] == 0) && ((a[9:0] == 0) || !c_SUB);
        zb = (b[14:10] == 0) && ((b[9:0] == 0) || !c_SUB);
        sp = na | nb | ia | ib | za | zb;
        rq = {sg, 15'h0000};
        rf = 7'b0001000;
        if (sa)                         begin rq = a | 16'h0200; rf = 7'b1000000; end
        else if (sb)                    begin rq = b | 16'h0200; rf = 7'b1000000; end
        else if (na)                    begin rq = a;            rf = 7'b0100000; end
        else if (nb)                    begin rq = b;            rf = 7'b0100000; end
        else if ((za && zb) || (ia && ib)) begin rq = 16'h7E00;  rf = 7'b0100000; end
        else if (ia)                    begin rq = {sg, 15'h7C00}; rf = 7'b0010000; end
        else if (zb)                    begin rq = {sg, 15'h7C00}; rf = 7'b0010001; end
        else if (za || ib)              begin rq = {sg, 15'h0000}; rf = 7'b0001000; end
        else begin
            x = h2r(a) / h2r(b);
            e = 0;
            while (x >= 2.0) begin x = x / 2.0; e++; end
            while (x < 1.0)  begin x = x * 2.0; e--; end
            if (c_SUB && e < -14) begin
                m = rne(x * pow2(e + 24));
                if (m >= 1024)   begin rq = {sg, 5'd1, 10'(m - 1024)}; rf = 7'b0000010; end
                else if (m == 0) begin rq = {sg, 15'h0000};            rf = 7'b0001000; end
                else             begin rq = {sg, 5'd0, m[9:0]};         rf = 7'b0000100; end
            end else begin
                m = rne(x * 1024.0);
                if (m == 2048) begin m = 1024; e++; end
                if (e > 15)       begin rq = {sg, 15'h7C00}; rf = 7'b0010000; end
                else if (e < -14) begin rq = {sg, 15'h0000}; rf = 7'b0001000; end
                else              begin rq = {sg, 5'(e + 15), 10'(m - 1024)}; rf = 7'b0000010; end
            end
        end
    endtask

    // Called on a negedge with the DUT idle; returns on a negedge after the result handshake
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input bit use_model, input logic [15:0] cq, input logic [6:0] cfl,
                          input bit csp);
        logic [15:0] eq;
        logic [6:0]  efl;
        logic [22:0] item;
        bit          sp;
        int          n, lat;
        if (use_model) model(a, b, eq, efl, sp);
        else begin eq = cq; efl = cfl; sp = csp; end
        op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back({eq, efl});
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
        check("latency", 32'(lat), sp ? 32'd1 : 32'd16);
        if (!out_valid) return;
        for (int i = 0; i < hold; i++) begin
            item = sb_q[0];
            check("hold_q", 32'(q), 32'(item[22:7]));
            check("hold_flags", 32'(w_fl), 32'(item[6:0]));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        item = sb_q.pop_front();
        check("q", 32'(q), 32'(item[22:7]));
        check("flags", 32'(w_fl), 32'(item[6:0]));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        logic [31:0] u;
        u = $urandom;
        case ($urandom_range(0, 9))
            0: r = u[15:0];
            1: case (u[2:0])
                3'd0: r = 16'h0000;  3'd1: r = 16'h8000;
                3'd2: r = 16'h7C00;  3'd3: r = 16'hFC00;
                3'd4: r = 16'h7E01;  3'd5: r = 16'h7C21;
                3'd6: r = 16'h0155;  default: r = 16'h83FF;
               endcase
            default: r = {u[15], 5'($urandom_range(3, 28)), u[9:0]};
        endcase
        return r;
    endfunction

    initial begin
        int cnt;
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = 16'h0; op_b = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_flags", 32'(w_fl), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h4200, 16'h3E00, 0, 0, 16'h4000, 7'b0000010, 0);
        run_op(16'h3C00, 16'h4200, 2, 0, 16'h3555, 7'b0000010, 0);
        run_op(16'h7BFF, 16'h3800, 0, 0, 16'h7C00, 7'b0010000, 0);
        run_op(16'h0000, 16'h0000, 0, 0, 16'h7E00, 7'b0100000, 1);
        run_op(16'h3C00, 16'h0000, 1, 0, 16'h7C00, 7'b0010001, 1);
        run_op(16'h7D00, 16'h3C00, 0, 0, 16'h7F00, 7'b1000000, 1);
        run_op(16'h7C00, 16'hFC00, 0, 0, 16'h7E00, 7'b0100000, 1);
        run_op(16'h3C00, 16'hFC00, 0, 0, 16'h8000, 7'b0001000, 1);
        run_op(16'hC000, 16'h3C00, 0, 0, 16'hC000, 7'b0000010, 0);
        if (c_SUB) run_op(16'h0400, 16'h4000, 0, 0, 16'h0200, 7'b0000100, 0);
        else       run_op(16'h0400, 16'h4000, 0, 0, 16'h0000, 7'b0001000, 0);
        run_op(16'h3C00, 16'h4200, 5, 0, 16'h3555, 7'b0000010, 0);

        // Abort an operation part-way through the iteration
        op_a = 16'h4200; op_b = 16'h3E00; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid) cnt++; end
        check("abort_no_beat", 32'(cnt), 32'd0);
        run_op(16'h4200, 16'h3E00, 0, 0, 16'h4000, 7'b0000010, 0);

        for (int i = 0; i < 60; i++)
            run_op(rand_op(), rand_op(), int'($urandom_range(0, 2)), 1, 16'h0, 7'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 No parameters; operand format fixed to IEEE-754 binary16.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  divider can accept operands.
REQ-006 op_a  input  16  dividend, binary16.
REQ-007 op_b  input  16  divisor, binary16.
REQ-008 out_valid  output  1  result beat valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 q  output  16  quotient op_a/op_b, binary16.
REQ-011 sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o  output  1 each  result class; exactly one high while out_valid=1.
REQ-012 div_zero_o  output  1  finite nonzero op_a divided by zero; accompanies infinity_o.

Function
REQ-013 Transfer on a port occurs only on a rising clk edge with valid=1 and ready=1.
REQ-014 States: IDLE, PRE, CALC, RND, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE: accept registers op_a/op_b and classifies both operands; special case -> DONE, otherwise -> PRE.
REQ-016 PRE, 1 cycle: unbias exponents; form 11-bit significands with hidden bit; subnormal operands left-normalised with exponent adjusted.
REQ-017 CALC, exactly 13 cycles: restoring division, one quotient bit per cycle; final remainder nonzero sets sticky.
REQ-018 Exponent arithmetic: signed, at least 8 bits, no wrap; exp_q = exp_a - exp_b, minus 1 if quotient MSB=0 (shift left one).
REQ-019 RND, 1 cycle: round to nearest, ties to even, on 10 fraction bits using guard plus sticky; a round carry out of the significand increments the exponent.
REQ-020 Latency: acceptance at edge T; out_valid=1 after edge T+16 for finite nonzero operands and after edge T+1 for special cases.
REQ-021 DONE: q and flags held stable while out_valid=1 and out_ready=0; on handshake -> IDLE and out_valid=0.
REQ-022 Sign: q[15] = op_a[15] XOR op_b[15] for all non-NaN results.
REQ-023 Any sNaN operand (op_a first): q = that operand with bit 9 set; sNaN_o=1.
REQ-024 Otherwise any qNaN operand (op_a first): q = that operand; qNaN_o=1.
REQ-025 0/0 or inf/inf: q=16'h7E00; qNaN_o=1.
REQ-026 inf/finite: signed infinity; infinity_o=1.
REQ-027 finite nonzero/0: signed infinity; infinity_o=1 and div_zero_o=1.
REQ-028 0/nonzero or finite/inf: signed zero; zero_o=1.
REQ-029 Overflow (exp_q > 15 after rounding): signed infinity; infinity_o=1.
REQ-030 Underflow handled per Configuration; a result rounding up to 2^-14 is reported normal_o.

Reset
REQ-031 rst_n=0 forces state IDLE, in_ready=1, out_valid=0, q=0, all flags 0, internal registers cleared.
REQ-032 Reset during PRE/CALC/RND/DONE aborts the operation; no result beat is ever produced for it.

Configuration
REQ-033 Macro FP_DIV_SUBNORMAL_EN.
REQ-034 Defined: subnormal operands normalised in PRE; exp_q < -14 yields a subnormal q, right-shifted before rounding, with shifted-out bits ORed into sticky; subnormal_o=1; a result rounding to 0 is signed zero with zero_o=1.
REQ-035 Undefined: subnormal operands treated as signed zero; exp_q < -14 flushed to signed zero with zero_o=1; subnormal_o tied 0; latency unchanged.

Verification
REQ-036 0x4200/0x3E00 (3.0/1.5) -> q=0x4000, normal_o=1, out_valid 16 cycles after acceptance.
REQ-037 0x3C00/0x4200 (1/3) -> q=0x3555 (RNE), normal_o=1; 0x7BFF/0x3800 -> q=0x7C00, infinity_o=1.
REQ-038 0x0000/0x0000 -> 0x7E00 qNaN_o; 0x3C00/0x0000 -> 0x7C00 infinity_o+div_zero_o; 0x7D00/0x3C00 -> 0x7F00 sNaN_o; each out_valid 1 cycle after acceptance.
REQ-039 0x0400/0x4000 -> with FP_DIV_SUBNORMAL_EN q=0x0200 subnormal_o; without q=0x0000 zero_o.
REQ-040 Hold out_ready=0 for 5 cycles at DONE -> q and flags stable, in_ready=0; release -> handshake completes, in_ready=1 the next cycle.
REQ-041 Assert rst_n=0 mid-CALC -> out_valid stays 0, in_ready=1 after reset; the next operation completes with correct latency.
